// File: rtl/alu_sequencer_project_id_pkg.sv
// Shared encodings for the ALU sequencer: phase numbers, opcode nibbles,
// ALU select encodings and the writeback mask.
package alu_sequencer_project_id_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OPR_INC     = 4'h6;
    localparam logic [3:0] OPR_ADD     = 4'h8;
    localparam logic [3:0] OPR_SUB     = 4'h9;
    localparam logic [3:0] OPR_LD      = 4'hA;
    localparam logic [3:0] OPR_LDM     = 4'hD;
    localparam logic [3:0] OPR_ACC_GRP = 4'hF;

    typedef enum logic [2:0] {
        ALU_OP_PASS  = 3'd0,
        ALU_OP_ADD   = 3'd1,
        ALU_OP_ROL   = 3'd2,
        ALU_OP_ROR   = 3'd3,
        ALU_OP_DEC_A = 3'd4,
        ALU_OP_LG2_1 = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_IN0_ACC     = 3'd0,
        ALU_IN0_ACC_INV = 3'd1,
        ALU_IN0_REG     = 3'd2,
        ALU_IN0_REG_INV = 3'd3,
        ALU_IN0_DATA    = 3'd4
    } alu_in0_e;

    typedef enum logic [1:0] {
        ALU_IN1_ZERO    = 2'd0,
        ALU_IN1_ACC     = 2'd1,
        ALU_IN1_ONE     = 2'd2,
        ALU_IN1_ONE_INV = 2'd3
    } alu_in1_e;

    typedef enum logic [1:0] {
        ALU_CIN_CARRY     = 2'd0,
        ALU_CIN_CARRY_INV = 2'd1,
        ALU_CIN_ZERO      = 2'd2,
        ALU_CIN_ONE       = 2'd3
    } alu_cin_e;

    typedef struct packed {
        logic acc;
        logic carry;
        logic rf;
    } wr_mask_t;

    // Opcodes whose following word is an address/data operand, not an instruction.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
               ((opr == 4'h2) && !opa[0]);
    endfunction

endpackage

// File: rtl/alu_decode_project_id.sv
// Pure combinational decode of the latched instruction nibbles into ALU
// selects, immediate data and the writeback mask.
module alu_decode_project_id
    import alu_sequencer_project_id_pkg::*;
(
    input  logic [3:0] opr,
    input  logic [3:0] opa,
    input  logic       carry,
    output alu_op_e    alu_op,
    output alu_in0_e   in0_sel,
    output alu_in1_e   in1_sel,
    output alu_cin_e   cin_sel,
    output logic [3:0] imm,
    output wr_mask_t   wr_mask
);

    always_comb begin
        // NOTE: every output is defaulted first so no decode path can infer a latch.
        alu_op  = ALU_OP_PASS;
        in0_sel = ALU_IN0_ACC;
        in1_sel = ALU_IN1_ZERO;
        cin_sel = ALU_CIN_CARRY;
        imm     = 4'h0;
        wr_mask = '0;

        case (opr)
            OPR_INC: begin
                alu_op = ALU_OP_ADD; in0_sel = ALU_IN0_REG; in1_sel = ALU_IN1_ONE;
                cin_sel = ALU_CIN_ZERO; wr_mask.rf = 1'b1;
            end
            OPR_ADD: begin
                alu_op = ALU_OP_ADD; in0_sel = ALU_IN0_REG; in1_sel = ALU_IN1_ACC;
                wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
            end
            OPR_SUB: begin
                alu_op = ALU_OP_ADD; in0_sel = ALU_IN0_REG_INV; in1_sel = ALU_IN1_ACC;
                cin_sel = ALU_CIN_CARRY_INV; wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
            end
            OPR_LD: begin
                in0_sel = ALU_IN0_REG; wr_mask.acc = 1'b1;
            end
            OPR_LDM: begin
                in0_sel = ALU_IN0_DATA; imm = opa; cin_sel = ALU_CIN_ZERO; wr_mask.acc = 1'b1;
            end
            OPR_ACC_GRP: begin
                case (opa)
                    4'h0: begin
                        in0_sel = ALU_IN0_DATA; cin_sel = ALU_CIN_ZERO;
                        wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
                    end
                    4'h1: begin cin_sel = ALU_CIN_ZERO; wr_mask.carry = 1'b1; end
                    4'h2: begin
                        alu_op = ALU_OP_ADD; in1_sel = ALU_IN1_ONE; cin_sel = ALU_CIN_ZERO;
                        wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
                    end
                    4'h3: begin cin_sel = ALU_CIN_CARRY_INV; wr_mask.carry = 1'b1; end
                    4'h4: begin in0_sel = ALU_IN0_ACC_INV; wr_mask.acc = 1'b1; end
                    4'h5: begin alu_op = ALU_OP_ROL; wr_mask.acc = 1'b1; wr_mask.carry = 1'b1; end
                    4'h6: begin alu_op = ALU_OP_ROR; wr_mask.acc = 1'b1; wr_mask.carry = 1'b1; end
                    4'h7: begin
                        in0_sel = ALU_IN0_DATA; imm = {3'b000, carry}; cin_sel = ALU_CIN_ZERO;
                        wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
                    end
                    4'h8: begin
                        alu_op = ALU_OP_ADD; in1_sel = ALU_IN1_ONE_INV; cin_sel = ALU_CIN_ONE;
                        wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
                    end
                    4'h9: begin
                        in0_sel = ALU_IN0_DATA; imm = carry ? 4'hA : 4'h9; cin_sel = ALU_CIN_ZERO;
                        wr_mask.acc = 1'b1; wr_mask.carry = 1'b1;
                    end
                    4'hA: begin cin_sel = ALU_CIN_ONE; wr_mask.carry = 1'b1; end
                    4'hB: begin alu_op = ALU_OP_DEC_A; wr_mask.acc = 1'b1; wr_mask.carry = 1'b1; end
                    4'hC: begin alu_op = ALU_OP_LG2_1; wr_mask.acc = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer_project_id.sv
// Instruction-cycle sequencer: 8-phase counter, OPR/OPA latches, two-word
// tracking and X2 writeback strobe gating in front of the ALU.
module alu_sequencer_project_id
    import alu_sequencer_project_id_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] bus,
    input  logic       carry,
    output logic [2:0] phase,
    output logic       sync,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic [3:0] reg_addr,
    output logic [3:0] imm,
    output logic [2:0] alu_op,
    output logic [2:0] alu_in0_sel,
    output logic [1:0] alu_in1_sel,
    output logic [1:0] alu_cin_sel,
    output logic       acc_we,
    output logic       carry_we,
    output logic       reg_we
);

    logic [2:0] phase_q;
    logic [3:0] opr_q;
    logic [3:0] opa_q;
    logic       second_word_q;

    alu_op_e    dec_op;
    alu_in0_e   dec_in0;
    alu_in1_e   dec_in1;
    alu_cin_e   dec_cin;
    wr_mask_t   dec_mask;
    logic       strobe_window;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_A1;
            opr_q         <= 4'h0;
            opa_q         <= 4'h0;
            second_word_q <= 1'b0;
        end else if (ena) begin
            phase_q <= phase_q + 3'd1;
            if (phase_q == PH_M1) opr_q <= bus;
            if (phase_q == PH_M2) opa_q <= bus;
            // An operand word is never itself treated as a first word, so the flag toggles off.
            if (phase_q == PH_X3) second_word_q <= !second_word_q && is_two_word(opr_q, opa_q);
        end
    end

    alu_decode_project_id u_decode (
        .opr     (opr_q),
        .opa     (opa_q),
        .carry   (carry),
        .alu_op  (dec_op),
        .in0_sel (dec_in0),
        .in1_sel (dec_in1),
        .cin_sel (dec_cin),
        .imm     (imm),
        .wr_mask (dec_mask)
    );

    // X2 lasts exactly one enabled cycle, so gating with ena yields a single strobe.
    assign strobe_window = (phase_q == PH_X2) && ena && !second_word_q;

    assign phase       = phase_q;
    assign sync        = (phase_q == PH_X3);
    assign opr         = opr_q;
    assign opa         = opa_q;
    assign reg_addr    = opa_q;
    assign alu_op      = dec_op;
    assign alu_in0_sel = dec_in0;
    assign alu_in1_sel = dec_in1;
    assign alu_cin_sel = dec_cin;
    assign acc_we      = strobe_window && dec_mask.acc;
    assign carry_we    = strobe_window && dec_mask.carry;
    assign reg_we      = strobe_window && dec_mask.rf;

endmodule
